// File: rtl/waveform_sequencer.sv
// Playback sequencer for one waveform channel: latches the run configuration,
// enables the waveform clock and steps the sample address on each tick.
module waveform_sequencer #(
  parameter int ADDR_WIDTH  = 10,
  parameter int PSC_WIDTH   = 16,
  parameter int BURST_WIDTH = 8
) (
  input  logic                   sys_clk_i,
  input  logic                   sys_rst_i,
  input  logic                   start_i,
  input  logic                   stop_i,
  input  logic                   mode_i,
  input  logic [PSC_WIDTH-1:0]   psc_i,
  input  logic [ADDR_WIDTH-1:0]  len_i,
  input  logic [BURST_WIDTH-1:0] burst_i,
  input  logic                   wc_clk_p_i,
  output logic                   wc_en_o,
  output logic [PSC_WIDTH-1:0]   wc_psc_o,
  output logic [ADDR_WIDTH-1:0]  addr_o,
  output logic                   addr_vld_o,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   err_o
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ARM  = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;

  localparam logic [ADDR_WIDTH-1:0]  ADDR_ONE  = 1;
  localparam logic [BURST_WIDTH-1:0] BURST_ONE = 1;

  logic [1:0]             state_q, state_d;
  logic                   mode_q, mode_d;
  logic [PSC_WIDTH-1:0]   psc_q, psc_d;
  logic [ADDR_WIDTH-1:0]  len_q, len_d;
  logic [BURST_WIDTH-1:0] burst_q, burst_d;
  logic [BURST_WIDTH-1:0] cnt_q, cnt_d;
  logic                   stop_q, stop_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic                   vld_q, vld_d;
  logic                   en_q, en_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   err_q, err_d;

  logic                   cfg_ok;
  logic [ADDR_WIDTH-1:0]  last_addr;
  logic [BURST_WIDTH-1:0] cnt_inc;
  logic                   burst_end;

  assign cfg_ok    = (psc_i != '0) && (len_i != '0) && (!mode_i || (burst_i != '0));
  assign last_addr = len_q - ADDR_ONE;
  assign cnt_inc   = cnt_q + BURST_ONE;
  assign burst_end = mode_q && (cnt_inc == burst_q);

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    psc_d   = psc_q;
    len_d   = len_q;
    burst_d = burst_q;
    cnt_d   = cnt_q;
    stop_d  = stop_q;
    addr_d  = addr_q;
    en_d    = en_q;
    busy_d  = busy_q;
    vld_d   = 1'b0;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          if (cfg_ok) begin
            mode_d  = mode_i;
            psc_d   = psc_i;
            len_d   = len_i;
            burst_d = burst_i;
            cnt_d   = '0;
            stop_d  = 1'b0;
            addr_d  = '0;
            vld_d   = 1'b1;
            en_d    = 1'b1;
            busy_d  = 1'b1;
            state_d = S_ARM;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_ARM: begin
        if (stop_i) stop_d = 1'b1;
        state_d = S_RUN;
      end
      S_RUN: begin
        if (stop_i) stop_d = 1'b1;
        // The tick is only looked at here; it may float while the clock is disabled.
        if (wc_clk_p_i) begin
          if (addr_q < last_addr) begin
            addr_d = addr_q + ADDR_ONE;
            vld_d  = 1'b1;
          end else if (stop_q || stop_i || burst_end) begin
            state_d = S_IDLE;
            en_d    = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            addr_d  = '0;
          end else begin
            addr_d = '0;
            vld_d  = 1'b1;
            if (mode_q) cnt_d = cnt_inc;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk_i or negedge sys_rst_i) begin
    if (!sys_rst_i) begin
      state_q <= S_IDLE;
      mode_q  <= 1'b0;
      psc_q   <= '0;
      len_q   <= '0;
      burst_q <= '0;
      cnt_q   <= '0;
      stop_q  <= 1'b0;
      addr_q  <= '0;
      vld_q   <= 1'b0;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      psc_q   <= psc_d;
      len_q   <= len_d;
      burst_q <= burst_d;
      cnt_q   <= cnt_d;
      stop_q  <= stop_d;
      addr_q  <= addr_d;
      vld_q   <= vld_d;
      en_q    <= en_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign wc_en_o    = en_q;
  assign wc_psc_o   = psc_q;
  assign addr_o     = addr_q;
  assign addr_vld_o = vld_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign err_o      = err_q;

endmodule

// File: tb/tb_waveform_sequencer.sv
// Bench for waveform_sequencer: a behavioural waveform clock feeds ticks, and a
// scoreboard of expected sample addresses is checked against every addr_vld_o pulse.
module tb_waveform_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_i = 1'b0;
  logic        stop_i = 1'b0;
  logic        mode_i = 1'b0;
  logic [15:0] psc_i = '0;
  logic [9:0]  len_i = '0;
  logic [7:0]  burst_i = '0;
  logic        gen_tick = 1'b0;
  logic        man_tick = 1'b0;
  logic        wc_tick;
  logic        wc_en_o;
  logic [15:0] wc_psc_o;
  logic [9:0]  addr_o;
  logic        addr_vld_o;
  logic        busy_o;
  logic        done_o;
  logic        err_o;

  int checks = 0;
  int errors = 0;

  logic [9:0] sb[$];
  int done_cnt = 0;
  int err_cnt = 0;
  int vld_cnt = 0;
  int cyc_n = 0;
  int last_vld = -1;
  int last_gap = 0;
  logic prev_tick = 1'b0;
  logic done_en, done_busy, done_vld, done_prev_tick;
  logic [9:0] done_addr;

  assign wc_tick = gen_tick | man_tick;

  waveform_sequencer #(.ADDR_WIDTH(10), .PSC_WIDTH(16), .BURST_WIDTH(8)) dut (
    .sys_clk_i (clk),
    .sys_rst_i (rst_n),
    .start_i   (start_i),
    .stop_i    (stop_i),
    .mode_i    (mode_i),
    .psc_i     (psc_i),
    .len_i     (len_i),
    .burst_i   (burst_i),
    .wc_clk_p_i(wc_tick),
    .wc_en_o   (wc_en_o),
    .wc_psc_o  (wc_psc_o),
    .addr_o    (addr_o),
    .addr_vld_o(addr_vld_o),
    .busy_o    (busy_o),
    .done_o    (done_o),
    .err_o     (err_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc_n <= cyc_n + 1;

  // Behavioural waveform clock: one tick every wc_psc_o cycles while enabled.
  initial begin
    int gcnt;
    gcnt = 0;
    forever begin
      @(posedge clk);
      #1;
      if (wc_en_o) begin
        gcnt++;
        if (gcnt >= int'(wc_psc_o)) begin
          gen_tick = 1'b1;
          gcnt = 0;
        end else begin
          gen_tick = 1'b0;
        end
      end else begin
        gcnt = 0;
        gen_tick = 1'b0;
      end
    end
  end

  // Scoreboard consumer and pulse bookkeeping.
  always @(negedge clk) begin
    if (addr_vld_o) begin
      vld_cnt++;
      if (last_vld >= 0) last_gap = cyc_n - last_vld;
      last_vld = cyc_n;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected_vld: got addr %0d, expected no pulse", addr_o);
      end else begin
        logic [9:0] exp_a;
        exp_a = sb.pop_front();
        if (addr_o !== exp_a) begin
          errors++;
          $display("FAIL sb_addr: got %0d, expected %0d", addr_o, exp_a);
        end
      end
    end
    if (done_o) begin
      done_cnt++;
      done_en = wc_en_o;
      done_busy = busy_o;
      done_vld = addr_vld_o;
      done_addr = addr_o;
      done_prev_tick = prev_tick;
    end
    if (err_o) err_cnt++;
    prev_tick = wc_tick;
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic do_start(input logic m, input logic [15:0] p, input logic [9:0] l,
                          input logic [7:0] b);
    mode_i = m; psc_i = p; len_i = l; burst_i = b;
    start_i = 1'b1;
    cyc();
    start_i = 1'b0;
  endtask

  task automatic wait_done(input int base, input int budget, output bit ok);
    int n = 0;
    while (done_cnt == base && n < budget) begin
      cyc();
      n++;
    end
    ok = (done_cnt != base);
  endtask

  task automatic wait_sb(input int level, input int budget, output bit ok);
    int n = 0;
    while (sb.size() > level && n < budget) begin
      cyc();
      n++;
    end
    ok = (sb.size() <= level);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) cyc();
    checks++;
    if ({wc_en_o, addr_vld_o, busy_o, done_o, err_o} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b, expected 00000",
               {wc_en_o, addr_vld_o, busy_o, done_o, err_o});
    end
    checks++;
    if (addr_o !== 10'd0 || wc_psc_o !== 16'd0) begin
      errors++;
      $display("FAIL reset_data: got addr %0d psc %0d, expected 0 0", addr_o, wc_psc_o);
    end
    rst_n = 1'b1;
    cyc();
  endtask

  task automatic test_continuous();
    bit ok;
    int d0;
    d0 = done_cnt;
    for (int i = 0; i < 8; i++) sb.push_back(10'(i % 3));
    do_start(1'b0, 16'd4, 10'd3, 8'd0);
    checks++;
    if (wc_en_o !== 1'b1 || busy_o !== 1'b1 || wc_psc_o !== 16'd4) begin
      errors++;
      $display("FAIL cont_arm: got en %b busy %b psc %0d, expected 1 1 4",
               wc_en_o, busy_o, wc_psc_o);
    end
    wait_sb(0, 200, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL cont_timeout: %0d addresses left, expected 0", sb.size());
    end
    checks++;
    if (last_gap !== 4) begin
      errors++;
      $display("FAIL cont_gap: got %0d cycles, expected 4", last_gap);
    end
    checks++;
    if (done_cnt !== d0 || busy_o !== 1'b1) begin
      errors++;
      $display("FAIL cont_running: got done %0d busy %b, expected %0d 1",
               done_cnt - d0, busy_o, 0);
    end
    sb.push_back(10'd2);
    stop_i = 1'b1;
    cyc();
    stop_i = 1'b0;
    wait_done(d0, 50, ok);
    checks++;
    if (!ok || sb.size() != 0 || wc_en_o !== 1'b0 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL cont_stop: got done %b left %0d en %b busy %b, expected 1 0 0 0",
               ok, sb.size(), wc_en_o, busy_o);
    end
    repeat (3) cyc();
  endtask

  task automatic test_burst();
    bit ok;
    int d0;
    d0 = done_cnt;
    for (int i = 0; i < 8; i++) sb.push_back(10'(i % 4));
    do_start(1'b1, 16'd2, 10'd4, 8'd2);
    wait_done(d0, 100, ok);
    checks++;
    if (!ok || sb.size() != 0) begin
      errors++;
      $display("FAIL burst_count: got done %b left %0d, expected 1 0", ok, sb.size());
    end
    checks++;
    if (done_en !== 1'b0 || done_busy !== 1'b0 || done_vld !== 1'b0 || done_addr !== 10'd0) begin
      errors++;
      $display("FAIL burst_done_state: got en %b busy %b vld %b addr %0d, expected 0 0 0 0",
               done_en, done_busy, done_vld, done_addr);
    end
    checks++;
    if (done_prev_tick !== 1'b1) begin
      errors++;
      $display("FAIL burst_done_latency: got tick-before-done %b, expected 1", done_prev_tick);
    end
    repeat (8) cyc();
    checks++;
    if (done_cnt !== d0 + 1) begin
      errors++;
      $display("FAIL burst_single_done: got %0d, expected %0d", done_cnt - d0, 1);
    end
  endtask

  task automatic test_stop();
    bit ok;
    int d0;
    int n;
    d0 = done_cnt;
    for (int i = 0; i < 3; i++) sb.push_back(10'(i));
    do_start(1'b0, 16'd3, 10'd5, 8'd0);
    n = 0;
    while (addr_o !== 10'd2 && n < 100) begin cyc(); n++; end
    checks++;
    if (addr_o !== 10'd2) begin
      errors++;
      $display("FAIL stop_reach2: got addr %0d, expected 2", addr_o);
    end
    sb.push_back(10'd3);
    sb.push_back(10'd4);
    stop_i = 1'b1;
    cyc();
    stop_i = 1'b0;
    wait_done(d0, 50, ok);
    checks++;
    if (!ok || sb.size() != 0 || done_addr !== 10'd0) begin
      errors++;
      $display("FAIL stop_graceful: got done %b left %0d addr %0d, expected 1 0 0",
               ok, sb.size(), done_addr);
    end
    repeat (4) cyc();
    d0 = done_cnt;
    for (int i = 0; i < 5; i++) sb.push_back(10'(i));
    do_start(1'b0, 16'd3, 10'd5, 8'd0);
    n = 0;
    while (!(addr_o === 10'd4 && wc_tick === 1'b1) && n < 100) begin cyc(); n++; end
    stop_i = 1'b1;
    cyc();
    stop_i = 1'b0;
    checks++;
    if (done_o !== 1'b1 || busy_o !== 1'b0 || sb.size() != 0) begin
      errors++;
      $display("FAIL stop_coincident: got done %b busy %b left %0d, expected 1 0 0",
               done_o, busy_o, sb.size());
    end
    repeat (5) cyc();
  endtask

  task automatic test_errors();
    logic        m[3] = '{1'b0, 1'b1, 1'b0};
    logic [15:0] p[3] = '{16'd0, 16'd2, 16'd2};
    logic [9:0]  l[3] = '{10'd3, 10'd3, 10'd0};
    logic [7:0]  b[3] = '{8'd1, 8'd0, 8'd1};
    for (int i = 0; i < 3; i++) begin
      do_start(m[i], p[i], l[i], b[i]);
      checks++;
      if (err_o !== 1'b1 || wc_en_o !== 1'b0 || busy_o !== 1'b0) begin
        errors++;
        $display("FAIL err_pulse%0d: got err %b en %b busy %b, expected 1 0 0",
                 i, err_o, wc_en_o, busy_o);
      end
      cyc();
      checks++;
      if (err_o !== 1'b0 || wc_en_o !== 1'b0) begin
        errors++;
        $display("FAIL err_clear%0d: got err %b en %b, expected 0 0", i, err_o, wc_en_o);
      end
    end
  endtask

  task automatic test_len1();
    bit ok;
    int d0, e0;
    d0 = done_cnt;
    e0 = err_cnt;
    for (int i = 0; i < 3; i++) sb.push_back(10'd0);
    stop_i = 1'b1;
    do_start(1'b1, 16'd1, 10'd1, 8'd3);
    stop_i = 1'b0;
    do_start(1'b0, 16'd0, 10'd0, 8'd0);
    wait_done(d0, 30, ok);
    checks++;
    if (!ok || sb.size() != 0 || done_prev_tick !== 1'b1) begin
      errors++;
      $display("FAIL len1_burst: got done %b left %0d tick %b, expected 1 0 1",
               ok, sb.size(), done_prev_tick);
    end
    repeat (4) cyc();
    checks++;
    if (err_cnt !== e0 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL len1_busy_start: got err %0d busy %b, expected 0 0", err_cnt - e0, busy_o);
    end
  endtask

  task automatic test_async_reset();
    bit ok;
    int d0, v0;
    d0 = done_cnt;
    for (int i = 0; i < 6; i++) sb.push_back(10'(i % 3));
    do_start(1'b0, 16'd2, 10'd3, 8'd0);
    wait_sb(3, 100, ok);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({wc_en_o, addr_vld_o, busy_o, done_o, err_o} !== 5'b0 || addr_o !== 10'd0 ||
        wc_psc_o !== 16'd0) begin
      errors++;
      $display("FAIL async_reset: got ctrl %b addr %0d psc %0d, expected 0 0 0",
               {wc_en_o, addr_vld_o, busy_o, done_o, err_o}, addr_o, wc_psc_o);
    end
    sb.delete();
    repeat (2) cyc();
    rst_n = 1'b1;
    v0 = vld_cnt;
    man_tick = 1'b1;
    repeat (10) cyc();
    man_tick = 1'b0;
    checks++;
    if (vld_cnt !== v0 || done_cnt !== d0 || wc_en_o !== 1'b0 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_idle: got vld %0d done %0d en %b busy %b, expected 0 0 0 0",
               vld_cnt - v0, done_cnt - d0, wc_en_o, busy_o);
    end
  endtask

  initial begin
    test_reset();
    test_continuous();
    test_burst();
    test_stop();
    test_errors();
    test_len1();
    test_async_reset();
    repeat (3) cyc();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/waveform_sequencer.md
Name: waveform_sequencer

Overview:
- Controls one waveform playback channel.
- Latches the run configuration and drives the enable and prescaler of the waveform clock generator.
- Consumes the generator's one-cycle sample tick and steps the waveform-memory read address on each tick.
- Supports continuous playback and burst playback (N full periods), with a graceful stop at the period boundary.

Parameters:
ADDR_WIDTH, 10, waveform memory address width; also the width of the sample-length field.
PSC_WIDTH, 16, prescaler width; must match the waveform clock prescaler input.
BURST_WIDTH, 8, width of the burst period count.

Ports:
sys_clk_i  in  1  system clock.
sys_rst_i  in  1  reset; asynchronous, active-low.
start_i  in  1  one-cycle start request.
stop_i  in  1  one-cycle graceful stop request.
mode_i  in  1  0 = continuous, 1 = burst; sampled at start.
psc_i  in  PSC_WIDTH  prescaler value; sampled at start.
len_i  in  ADDR_WIDTH  samples per period; sampled at start.
burst_i  in  BURST_WIDTH  periods per burst; sampled at start.
wc_clk_p_i  in  1  sample tick from the waveform clock; may be Z while disabled.
wc_en_o  out  1  waveform clock enable.
wc_psc_o  out  PSC_WIDTH  latched prescaler to the waveform clock.
addr_o  out  ADDR_WIDTH  current sample address.
addr_vld_o  out  1  one-cycle pulse: addr_o holds a new sample address.
busy_o  out  1  high in ARM and RUN.
done_o  out  1  one-cycle pulse at playback end.
err_o  out  1  one-cycle pulse when a start is rejected.

Behaviour:
- Reset (sys_rst_i = 0, asynchronous): state IDLE; all outputs 0; all latches and counters 0.
- Any reset assertion, including mid-run, aborts immediately. No done_o is produced. A new start_i is required after release.
- States: IDLE, ARM, RUN. All outputs are registered.
- IDLE:
  - start_i with a valid config latches mode, psc, len and burst; clears the stop flag and period count; next state ARM.
  - Valid config: psc_i >= 1, len_i >= 1, and (mode_i = 0 or burst_i >= 1).
  - Invalid config: err_o = 1 for the next cycle; state stays IDLE; wc_en_o stays 0.
  - stop_i in IDLE is ignored. start_i together with stop_i in IDLE starts normally.
- ARM (exactly one cycle):
  - wc_en_o = 1 and wc_psc_o = latched psc; both remain stable until the return to IDLE.
  - addr_o = 0, addr_vld_o = 1 (first sample).
  - Next state RUN.
  - wc_clk_p_i is ignored in ARM and IDLE; never sample a Z/X tick outside RUN.
- RUN: on each cycle with wc_clk_p_i = 1 (tick at cycle n):
  - If addr_o < len-1: addr_o <= addr_o+1 and addr_vld_o = 1 at n+1.
  - If addr_o = len-1 (period boundary):
    - Terminate if the stop flag is set, or stop_i = 1 in this same cycle, or (mode = 1 and period count + 1 = burst).
    - Terminate means: at n+1 state IDLE, wc_en_o = 0, busy_o = 0, done_o = 1, addr_o = 0, no addr_vld_o.
    - Otherwise: addr_o <= 0, period count +1 (burst mode only), addr_vld_o = 1 at n+1.
- stop_i in ARM or RUN sets a sticky stop flag. Playback ends at the next period boundary; the current period always completes.
- start_i while busy is ignored, with no err_o.
- len = 1: every tick is a period boundary; addr_o stays 0 and addr_vld_o pulses on each non-terminating tick.
- Continuous mode: the period count does not advance; it runs until stop.
- Arithmetic: the address compare uses the full ADDR_WIDTH. The period count is BURST_WIDTH wide and never exceeds burst-1.
- Ticks are at least one cycle apart because the prescaler is >= 1. Back-to-back ticks (psc = 1) must be handled every cycle with no dropped step.

Test Plan:
1. Continuous mode, psc=4, len=3, start: addr_vld_o in ARM with addr 0, then one cycle after each tick; sequence 0,1,2,0,1,2,... every 4 cycles; done_o never asserts.
2. Burst mode, psc=2, len=4, burst=2: exactly 8 addr_vld_o pulses (0,1,2,3,0,1,2,3). done_o=1 and wc_en_o=0 one cycle after the 8th tick. busy_o deasserts in the same cycle as done_o.
3. Continuous mode, len=5, stop_i while addr_o=2: addresses 3 and 4 still issued. On the tick at addr 4, done_o=1 with no wrap to 0. Repeat with stop_i coincident with the boundary tick: terminates on that tick.
4. start_i with psc=0, then with mode=1 and burst=0, then with len=0: err_o pulses once for each; wc_en_o and busy_o stay 0.
5. Burst mode, len=1, burst=3, psc=1: 3 addr_vld_o pulses, all at addr 0; done_o one cycle after the 3rd tick. A second start_i issued mid-run is ignored.
6. Assert sys_rst_i low mid-RUN, asynchronously between clock edges: all outputs 0 before the next edge; no done_o. After release, ticks alone produce no activity until start_i.
